// File: rtl/pipe_pkg.sv
// Shared types and constants for the valid/ready pipeline stage registers.
// Stage payload widths are the concatenated field widths of each boundary.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    typedef enum logic [1:0] {
        MAIN_HOLD      = 2'd0,
        MAIN_LOAD_IN   = 2'd1,
        MAIN_LOAD_SKID = 2'd2,
        MAIN_CLEAR     = 2'd3
    } main_op_t;

    typedef enum logic [1:0] {
        SKID_HOLD    = 2'd0,
        SKID_LOAD_IN = 2'd1,
        SKID_CLEAR   = 2'd2
    } skid_op_t;

    // A zero instruction word decodes as a NOP, so zeroed bubbles are harmless.
    localparam bit NOP_PAYLOAD_ZERO = 1'b1;

    localparam int IFID_W            = 64;
    localparam int IDEX_W            = 197;
    localparam int EXMEM_W           = 101;
    localparam int MEMWB_W           = 69;
    localparam int DEFAULT_PAYLOAD_W = IDEX_W;

endpackage

// File: rtl/pipe_skid_stage_sat_counter.sv
// Saturating event counter: counts cycles where inc is high, sticks at all-ones.
// Cleared only by the synchronous active-low reset.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_r;

    // Count register with saturation at all-ones.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (inc && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline stage register with a 2-entry skid buffer, flush with
// optional bubble zeroing, and saturating stall/bubble performance counters.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W   = DEFAULT_PAYLOAD_W,
    parameter bit ZERO_BUBBLE = NOP_PAYLOAD_ZERO,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     bubble_cnt
);

    // Clearing main whenever the stage drains keeps out_data at zero while
    // out_valid=0 without a mask after the register.
    localparam main_op_t MAIN_DROP = ZERO_BUBBLE ? MAIN_CLEAR : MAIN_HOLD;
    localparam skid_op_t SKID_DROP = ZERO_BUBBLE ? SKID_CLEAR : SKID_HOLD;

    skid_state_t          state_r;
    skid_state_t          state_next_s;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic [PAYLOAD_W-1:0] main_r;
    logic [PAYLOAD_W-1:0] skid_r;
    main_op_t             main_op_s;
    skid_op_t             skid_op_s;
    logic                 in_xfer_s;
    logic                 out_xfer_s;

    assign in_xfer_s  = in_valid & in_ready_r;
    assign out_xfer_s = out_valid_r & out_ready;

    // State register; handshake outputs are flopped from the next state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s != FULL);
            out_valid_r <= (state_next_s != EMPTY);
        end
    end

    // Next-state logic; flush overrides every transfer.
    always_comb begin
        state_next_s = state_r;
        if (flush) begin
            state_next_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (in_xfer_s) state_next_s = ONE;
                    else           state_next_s = EMPTY;
                end
                ONE: begin
                    if (in_xfer_s && !out_xfer_s)      state_next_s = FULL;
                    else if (!in_xfer_s && out_xfer_s) state_next_s = EMPTY;
                    else                               state_next_s = ONE;
                end
                FULL: begin
                    if (out_xfer_s) state_next_s = ONE;
                    else            state_next_s = FULL;
                end
                default: state_next_s = EMPTY;
            endcase
        end
    end

    // Datapath control decoded from the current state and transfers.
    always_comb begin
        main_op_s = MAIN_HOLD;
        skid_op_s = SKID_HOLD;
        if (flush) begin
            main_op_s = MAIN_DROP;
            skid_op_s = SKID_DROP;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (in_xfer_s) main_op_s = MAIN_LOAD_IN;
                    else           main_op_s = MAIN_HOLD;
                end
                ONE: begin
                    if (in_xfer_s && out_xfer_s) main_op_s = MAIN_LOAD_IN;
                    else if (in_xfer_s)          skid_op_s = SKID_LOAD_IN;
                    else if (out_xfer_s)         main_op_s = MAIN_DROP;
                    else                         main_op_s = MAIN_HOLD;
                end
                FULL: begin
                    if (out_xfer_s) begin
                        main_op_s = MAIN_LOAD_SKID;
                        skid_op_s = SKID_DROP;
                    end else begin
                        main_op_s = MAIN_HOLD;
                    end
                end
                default: begin
                    main_op_s = MAIN_CLEAR;
                    skid_op_s = SKID_CLEAR;
                end
            endcase
        end
    end

    // Main and skid payload registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            main_r <= {PAYLOAD_W{1'b0}};
            skid_r <= {PAYLOAD_W{1'b0}};
        end else begin
            case (main_op_s)
                MAIN_LOAD_IN:   main_r <= in_data;
                MAIN_LOAD_SKID: main_r <= skid_r;
                MAIN_CLEAR:     main_r <= {PAYLOAD_W{1'b0}};
                default:        main_r <= main_r;
            endcase
            case (skid_op_s)
                SKID_LOAD_IN: skid_r <= in_data;
                SKID_CLEAR:   skid_r <= {PAYLOAD_W{1'b0}};
                default:      skid_r <= skid_r;
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = main_r;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (out_valid_r & ~out_ready),
        .cnt     (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (~out_valid_r),
        .cnt     (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: a 2-deep FIFO reference model plus
// directed scenarios on ZERO_BUBBLE=0 and CNT_W=3 instances.
module tb_pipe_skid_stage;

    localparam int PW = 197;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          flush;
    logic          in_valid;
    logic [PW-1:0] in_data;
    logic          out_ready;
    logic [31:0]   s_data;

    logic          in_ready, out_valid;
    logic [PW-1:0] out_data;
    logic [15:0]   stall_cnt, bubble_cnt;

    logic          nz_in_ready, nz_out_valid;
    logic [31:0]   nz_out_data;
    logic [15:0]   nz_stall_cnt, nz_bubble_cnt;

    logic          sat_in_ready, sat_out_valid;
    logic [31:0]   sat_out_data;
    logic [2:0]    sat_stall_cnt, sat_bubble_cnt;

    int            n_cmp = 0;
    int            n_bad = 0;
    bit            armed = 1'b0;
    logic [PW-1:0] exp_q[$];
    logic [15:0]   stall_m = 16'd0;
    logic [15:0]   bubble_m = 16'd0;
    bit            pend_valid = 1'b0;
    logic [PW-1:0] pend_data;

    assign s_data = in_data[31:0];

    always #5 clk = ~clk;

    pipe_skid_stage dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    pipe_skid_stage #(.PAYLOAD_W(32), .ZERO_BUBBLE(1'b0), .CNT_W(16)) dut_nz (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(nz_in_ready), .in_data(s_data),
        .out_valid(nz_out_valid), .out_ready(out_ready), .out_data(nz_out_data),
        .stall_cnt(nz_stall_cnt), .bubble_cnt(nz_bubble_cnt)
    );

    pipe_skid_stage #(.PAYLOAD_W(32), .ZERO_BUBBLE(1'b1), .CNT_W(3)) dut_sat (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(sat_in_ready), .in_data(s_data),
        .out_valid(sat_out_valid), .out_ready(out_ready), .out_data(sat_out_data),
        .stall_cnt(sat_stall_cnt), .bubble_cnt(sat_bubble_cnt)
    );

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] rand_payload();
        logic [PW-1:0] v = '0;
        for (int k = 0; k < 7; k++) v = (v << 32) | PW'($urandom);
        return v;
    endfunction

    // One cycle of stimulus; the word accepted in the previous cycle enters the scoreboard.
    task automatic cyc(input logic rn, input logic fl, input logic iv, input logic [PW-1:0] d, input logic ordy);
        @(posedge clk);
        #1;
        if (pend_valid) exp_q.push_back(pend_data);
        reset_n   = rn;
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        pend_valid = rn && !fl && iv && in_ready;
        pend_data  = d;
        armed = 1'b1;
    endtask

    // Monitor: compare DUT against FIFO model, then advance the model by this cycle.
    always @(negedge clk) begin
        if (armed) begin
            chk("out_valid", PW'(out_valid), PW'(exp_q.size() != 0));
            chk("in_ready", PW'(in_ready), PW'(exp_q.size() < 2));
            if (exp_q.size() != 0) chk("out_data", out_data, exp_q[0]);
            else                   chk("bubble_data", out_data, '0);
            chk("stall_cnt", PW'(stall_cnt), PW'(stall_m));
            chk("bubble_cnt", PW'(bubble_cnt), PW'(bubble_m));
            if (!reset_n) begin
                exp_q.delete();
                stall_m  = 16'd0;
                bubble_m = 16'd0;
            end else begin
                if (exp_q.size() == 0) begin
                    if (bubble_m != 16'hFFFF) bubble_m = bubble_m + 16'd1;
                end else if (!out_ready) begin
                    if (stall_m != 16'hFFFF) stall_m = stall_m + 16'd1;
                end
                if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
                if (flush) exp_q.delete();
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic r_in_ready, r_out_valid;
        logic [PW-1:0] r_out_data;
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = PW'(32'h77); out_ready = 1'b1;

        // Reset held two cycles with in_valid=1, then a back-to-back stream.
        cyc(1'b0, 1'b0, 1'b1, PW'(32'h77), 1'b1);
        @(negedge clk);
        chk("rst_out_valid", PW'(out_valid), PW'(1'b0));
        chk("rst_out_data", out_data, '0);
        chk("rst_in_ready", PW'(in_ready), PW'(1'b1));
        chk("rst_stall", PW'(stall_cnt), '0);
        chk("rst_bubble", PW'(bubble_cnt), '0);
        for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b0, 1'b1, PW'(i), 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);

        // Skid fill: A, then B while stalled three cycles.
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, PW'(32'hA), 1'b0);
        cyc(1'b1, 1'b0, 1'b1, PW'(32'hB), 1'b0);
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        chk("skid_in_ready", PW'(in_ready), PW'(1'b0));
        chk("skid_hold_a", out_data, PW'(32'hA));
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        chk("skid_stall3", PW'(stall_cnt), PW'(16'd3));
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);

        // Flush while FULL with C offered.
        cyc(1'b1, 1'b0, 1'b1, PW'(32'hA2), 1'b0);
        cyc(1'b1, 1'b0, 1'b1, PW'(32'hB2), 1'b0);
        cyc(1'b1, 1'b1, 1'b1, PW'(32'hC), 1'b0);
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        chk("flush_out_valid", PW'(out_valid), PW'(1'b0));
        chk("flush_out_data", out_data, '0);
        chk("flush_in_ready", PW'(in_ready), PW'(1'b1));
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);

        // Reset while FULL drops both entries.
        cyc(1'b1, 1'b0, 1'b1, PW'(32'h51), 1'b0);
        cyc(1'b1, 1'b0, 1'b1, PW'(32'h52), 1'b0);
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        chk("rstfull_out_valid", PW'(out_valid), PW'(1'b0));
        chk("rstfull_in_ready", PW'(in_ready), PW'(1'b1));

        // ZERO_BUBBLE=0: flush keeps old data; counters are not cleared.
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, PW'(32'hD), 1'b0);
        @(negedge clk);
        chk("nz_first_bubble", PW'(nz_bubble_cnt), PW'(16'd1));
        cyc(1'b1, 1'b1, 1'b0, '0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        chk("nz_out_valid", PW'(nz_out_valid), PW'(1'b0));
        chk("nz_out_data", PW'(nz_out_data), PW'(32'hD));
        chk("nz_stall", PW'(nz_stall_cnt), PW'(16'd1));
        chk("nz_bubble", PW'(nz_bubble_cnt), PW'(16'd2));

        // CNT_W=3 saturation.
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, PW'(32'hE), 1'b0);
        for (int i = 0; i < 11; i++) cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        chk("sat_stall", PW'(sat_stall_cnt), PW'(3'd7));
        for (int i = 0; i < 11; i++) cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        chk("sat_bubble", PW'(sat_bubble_cnt), PW'(3'd7));
        chk("sat_stall_hold", PW'(sat_stall_cnt), PW'(3'd7));

        // Random traffic with mid-cycle probes for combinational paths.
        for (int i = 0; i < 10000; i++) begin
            cyc(($urandom_range(0, 499) != 0), ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 9) < 7), rand_payload(), ($urandom_range(0, 9) < 6));
            if (i % 8 == 0) begin
                r_in_ready  = in_ready;
                r_out_valid = out_valid;
                r_out_data  = out_data;
                out_ready = ~out_ready; in_valid = ~in_valid; in_data = ~in_data;
                #1;
                chk("comb_in_ready", PW'(in_ready), PW'(r_in_ready));
                chk("comb_out_valid", PW'(out_valid), PW'(r_out_valid));
                chk("comb_out_data", out_data, r_out_data);
                out_ready = ~out_ready; in_valid = ~in_valid; in_data = ~in_data;
            end
        end
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
